// File: rtl/pc_stall_sched.sv
// Round-robin stall scheduler: grants one requester at a time and holds pcEn low
// for the granted cycle count. Optional stalled-cycle counter under `STALL_PERF_EN.
module pc_stall_sched #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] req_cycles,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  pcEn,
    output logic                  busy,
    output logic [15:0]           stall_cycles
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0] gidx_q, gidx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             found;
    logic [PTR_W-1:0] sel;
    logic [CNT_W-1:0] sel_len;
    int               idx;

    // First requester at or above ptr, wrapping around
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = PTR_W'(idx);
            end
        end
        sel_len = req_cycles[int'(sel)*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = (sel_len == '0) ? DONE : COUNT;
            COUNT:   if (count_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = NREQ'(1) << sel;
                    gidx_d  = sel;
                    count_d = sel_len;
                end
            end
            COUNT: count_d = count_q - CNT_W'(1);
            DONE: begin
                grant_d = '0;
                ptr_d   = (gidx_q == PTR_W'(NREQ-1)) ? '0 : gidx_q + PTR_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        grant = grant_q;
        done  = (state_q == DONE) ? grant_q : '0;
        pcEn  = (state_q != COUNT);
        busy  = (state_q != IDLE);
    end

`ifdef STALL_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;

    // Saturating count of cycles spent with pcEn low
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (state_q == COUNT && stall_cycles_q != 16'hFFFF)
            stall_cycles_d = stall_cycles_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_stall_sched.sv
// Scoreboard bench for pc_stall_sched: expected grants pushed at stimulus time,
// popped and compared (owner, pcEn-low length) on each done pulse.
module tb_pc_stall_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [11:0] req_cycles;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        pcEn;
    logic        busy;
    logic [15:0] stall_cycles;

    pc_stall_sched #(.NREQ(3), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_cycles   (req_cycles),
        .grant        (grant),
        .done         (done),
        .pcEn         (pcEn),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mask;
        int         len;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   low_cnt = 0;
    logic [15:0] stall_exp = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic set_len(input int src, input logic [3:0] n);
        req_cycles[src*4 +: 4] = n;
    endtask

    task automatic push_exp(input logic [2:0] m, input int len);
        exp_t e;
        e.mask = m;
        e.len  = len;
        sb_q.push_back(e);
    endtask

    // Returns on the negedge where done hits mask; optionally drops those requests
    task automatic wait_done(input logic [2:0] m, input int budget, input bit drop);
        int n = 0;
        while ((done & m) == 3'b000 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((done & m) == 3'b000) chk("timeout_done", {29'd0, done}, {29'd0, m});
        if (drop) req = req & ~m;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        stall_exp = 16'd0;
    endtask

    // Monitor: measure each pcEn-low window and retire scoreboard entries on done
    always @(negedge clk) begin
        if (!busy)      low_cnt = 0;
        else if (!pcEn) low_cnt++;
        if (done != 3'b000) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_done", {29'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_done",  {29'd0, done},  {29'd0, e.mask});
                chk("sb_grant", {29'd0, grant}, {29'd0, e.mask});
                chk("sb_len",   low_cnt,        e.len);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 3'b000;
        req_cycles = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pcEn",  pcEn,  1);
        chk("rst_grant", grant, 0);
        chk("rst_done",  done,  0);
        chk("rst_busy",  busy,  0);
        chk("rst_stall", stall_cycles, 0);
        rst = 1'b0;

        // Single 5-cycle stall on source 0
        @(negedge clk);
        set_len(0, 4'd5);
        req = 3'b001;
        push_exp(3'b001, 5);
        @(negedge clk);
        chk("t1_grant", grant, 3'b001);
        chk("t1_pcEn",  pcEn,  0);
        chk("t1_busy",  busy,  1);
        wait_done(3'b001, 20, 1'b1);
        @(negedge clk);
`ifdef STALL_PERF_EN
        stall_exp = 16'd5;
`endif
        chk("t1_stall", stall_cycles, stall_exp);
        chk("t1_idle_busy", busy, 0);

        // Zero-length stall on source 1
        set_len(1, 4'd0);
        req = 3'b010;
        push_exp(3'b010, 0);
        @(negedge clk);
        chk("t2_grant", grant, 3'b010);
        chk("t2_done",  done,  3'b010);
        chk("t2_pcEn",  pcEn,  1);
        wait_done(3'b010, 4, 1'b1);
        @(negedge clk);
        chk("t2_stall", stall_cycles, stall_exp);

        // Fairness: all sources continuously requesting
        do_reset();
        set_len(0, 4'd2);
        set_len(1, 4'd3);
        set_len(2, 4'd1);
        for (int r = 0; r < 2; r++) begin
            push_exp(3'b001, 2);
            push_exp(3'b010, 3);
            push_exp(3'b100, 1);
        end
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            wait_done(3'b111, 20, 1'b0);
            if (k == 5) begin
                req = 3'b000;
            end else begin
                @(negedge clk);
                chk("rr_gap_idle", busy, 0);
                chk("rr_gap_pcEn", pcEn, 1);
                @(negedge clk);
                chk("rr_regrant", busy, 1);
            end
        end
        @(negedge clk);

        // Late arrival from source 2 during source 0's stall
        do_reset();
        set_len(0, 4'd4);
        req = 3'b001;
        push_exp(3'b001, 4);
        @(negedge clk);
        chk("late_grant0", grant, 3'b001);
        @(negedge clk);
        set_len(2, 4'd2);
        req = req | 3'b100;
        push_exp(3'b100, 2);
        @(negedge clk);
        chk("late_ignored", grant, 3'b001);
        wait_done(3'b001, 20, 1'b1);
        @(negedge clk);
        chk("late_idle", busy, 0);
        @(negedge clk);
        chk("late_grant2", grant, 3'b100);
        wait_done(3'b100, 20, 1'b1);
        @(negedge clk);

        // Reset in the 3rd cycle of a 10-cycle stall
        set_len(0, 4'd10);
        req = 3'b001;
        @(negedge clk);
        chk("mid_grant", grant, 3'b001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        stall_exp = 16'd0;
        chk("mid_pcEn",  pcEn,  1);
        chk("mid_grant0", grant, 0);
        chk("mid_busy",  busy,  0);
        chk("mid_done",  done,  0);
        chk("mid_stall", stall_cycles, 0);
        repeat (15) @(negedge clk);
        chk("mid_still_idle", busy, 0);

`ifdef STALL_PERF_EN
        // Saturation: 4667 x 15 stalled cycles exceeds 16'hFFFF
        do_reset();
        set_len(0, 4'd15);
        req = 3'b001;
        for (int k = 0; k < 4667; k++) begin
            push_exp(3'b001, 15);
            wait_done(3'b001, 40, 1'b0);
            if (k == 4666) req = 3'b000;
            @(negedge clk);
            if (k == 3999) chk("sat_mid", stall_cycles, 16'd60000);
        end
        chk("sat_hold", stall_cycles, 16'hFFFF);
        repeat (5) @(negedge clk);
        chk("sat_hold_idle", stall_cycles, 16'hFFFF);
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_stall_sched.md
# pc_stall_sched

Round-robin stall scheduler for the strawberry core's program-counter enable. It arbitrates between several stall sources (e.g. memory wait, multi-cycle ALU op, explicit delay instruction), each of which asks for a stall of a given cycle count. It runs one shared down-counter and drives `pcEn` low for exactly the granted number of cycles. It sits between the stall sources and the PC register.

## Interface

Parameters:
- `NREQ`, default 3: number of stall requesters.
- `CNT_W`, default 4: width of each requested stall length. Maximum stall is 2**CNT_W-1 cycles.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  level request per source; held until that source's `done` pulse.
- `req_cycles`  in  NREQ*CNT_W  stall length per source; source i occupies bits [i*CNT_W +: CNT_W]; sampled only at grant.
- `grant`  out  NREQ  one-hot owner of the counter; all-zero when idle.
- `done`  out  NREQ  one-cycle pulse to the granted source when its stall completes.
- `pcEn`  out  1  PC enable; 0 while a stall is being counted.
- `busy`  out  1  1 whenever state is not IDLE.
- `stall_cycles`  out  16  stalled-cycle counter (see Configuration).

## Operation

- FSM states: IDLE, COUNT, DONE. All outputs are registered, or decoded from registered state only.
- IDLE:
  - If any `req` bit is high, select the first high bit searching upward from round-robin pointer `ptr`, wrapping from NREQ-1 to 0.
  - Set `grant` one-hot for the selected source and load `count` with its `req_cycles` value N.
  - Go to COUNT if N>0; go directly to DONE if N==0.
- COUNT:
  - `pcEn`=0.
  - If `count`==1, go to DONE; otherwise decrement `count`.
  - `req` and `req_cycles` changes are ignored while in COUNT.
- DONE:
  - `done[g]`=1 and `pcEn`=1.
  - Next state is IDLE. `grant` clears to 0 and `ptr` becomes (g+1) mod NREQ.
- Requester rule: deassert `req` in the cycle after `done`. A `req` still high in IDLE is treated as a new request.
- Fairness: with all sources requesting continuously, grants rotate 0,1,2,0,...
- `pcEn` = (state != COUNT). `busy` = (state != IDLE).
- Reset, including mid-stall:
  - State returns to IDLE; `pcEn`=1; `grant`=0; `done`=0; `ptr`=0; `count`=0; `stall_cycles`=0.
  - An aborted stall produces no `done` pulse.

## Timing

- Request first high in IDLE cycle t with length N>0:
  - `grant` valid and `pcEn`=0 from cycle t+1 through t+N (exactly N cycles).
  - `done` pulses in cycle t+N+1.
  - Back in IDLE at t+N+2, where the next request can be accepted.
- N=0: `grant` and `done` both asserted in cycle t+1; `pcEn` never drops.
- Back-to-back stalls are separated by exactly one `pcEn`=1 cycle (the DONE cycle) plus one IDLE arbitration cycle.
- Simultaneous requests in the same cycle are resolved purely by `ptr`, with no fixed priority.
- A request that rises during COUNT or DONE waits. It is seen in the next IDLE cycle.

## Configuration

- Macro `STALL_PERF_EN`.
- Defined:
  - `stall_cycles` increments by 1 on every clock edge where `pcEn`=0.
  - It saturates at 16'hFFFF and does not wrap.
  - It is cleared only by `rst`.
- Undefined:
  - No counter logic is built and `stall_cycles` is tied to 16'h0000.
  - All other behaviour is identical.

## Test plan

- Reset then single request: `rst` held high for 2 cycles, then `req`=3'b001 with length 5 → `grant`=001 the next cycle, `pcEn` low for exactly 5 cycles, `done`=001 for one cycle, `stall_cycles`=5 when `STALL_PERF_EN` is defined (0 otherwise).
- Zero-length stall: `req`=010 with length 0 → `grant`=010 and `done`=010 in the same cycle; `pcEn` stays 1; `stall_cycles` unchanged.
- Round-robin fairness: all three requesters continuously re-request with lengths 2, 3, 1 → grant order 0,1,2,0,1,2; each `pcEn` low window matches its length; one IDLE cycle between stalls.
- Late arrival: `req`=100 raised mid-stall of source 0 → ignored until IDLE, then granted next ahead of source 0 (`ptr`=1 search reaches bit 2 first when bit 1 is idle).
- Reset mid-operation: `rst` pulsed in the 3rd cycle of a 10-cycle stall → next cycle `pcEn`=1, `grant`=0, `busy`=0; no `done` pulse; `stall_cycles`=0.
- Saturation (with `STALL_PERF_EN` defined): force 70000 stalled cycles using repeated 15-cycle stalls → `stall_cycles` holds at 16'hFFFF.
